axis_sim_pkt_sink: RTL
======================

Name: axis_sim_pkt_sink

Overview:
Synthesizable AXI4-Stream packet sink and checker for the switch's simulation top and for on-board loopback tests. It consumes packets leaving a switch output port and applies pseudo-random backpressure. It checks the tkeep, length and protocol rules, and keeps packet, byte and error statistics for the bench or the register block to read.

Parameters:
C_S_AXIS_DATA_WIDTH, 256, tdata width in bits; tkeep width is C_S_AXIS_DATA_WIDTH/8.
C_S_AXIS_TUSER_WIDTH, 128, tuser width; tuser[15:0] carries the packet length in bytes, tuser[23:16] the source port one-hot.
THROTTLE_PERCENT, 50, nominal percentage of cycles with tready low; legal range 0..99.
LFSR_SEED, 16'hACE1, nonzero reset value of the backpressure LFSR.
MIN_PKT_BYTES, 60, shortest legal packet.
MAX_PKT_BYTES, 1518, longest legal packet.

Ports:
axis_aclk  in  1  core clock
axis_resetn  in  1  synchronous active-low reset
s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  stream data
s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  byte enables, LSB-first
s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband metadata
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat accept, registered
s_axis_tlast  in  1  last beat of packet
enable  in  1  permits tready assertion
clear_stats  in  1  synchronous clear of all counters and flags
pkt_count  out  32  packets completed
byte_count  out  48  bytes accepted in completed packets
err_count  out  16  packets with at least one error, saturating
err_flags  out  4  sticky: [0] keep, [1] runt/giant, [2] length mismatch, [3] stall violation
last_pkt_len  out  16  byte length of the most recent packet
last_src_port  out  8  tuser[23:16] captured on the first beat of the most recent packet
busy  out  1  high while in S_PKT

Behaviour:
- Reset (axis_resetn=0 at a clock edge): all outputs are 0, the LFSR loads LFSR_SEED and the FSM goes to S_IDLE.
- Reset is synchronous and active-low.
- A beat is accepted when tvalid & tready.
- Backpressure LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle.
- THRESH = THROTTLE_PERCENT*256/100. Next tready = enable & (lfsr[7:0] >= THRESH).
- THROTTLE_PERCENT=0 gives tready=enable on the next cycle.
- enable low forces tready low on the next edge. A packet in progress stays in S_PKT.
- FSM S_IDLE: an accepted beat captures tuser[15:0] as the expected length and tuser[23:16] as the source port.
  - tlast=0 moves to S_PKT.
  - tlast=1 completes a single-beat packet and stays in S_IDLE.
- FSM S_PKT: accepted beats accumulate. The accepted tlast beat completes the packet and returns to S_IDLE.
- Beat byte count = popcount(tkeep), range 0..32. The running length is 16 bits and saturates at 16'hFFFF.
- Keep error: any of the following.
  - Non-last beat with tkeep not all ones.
  - Last beat with tkeep zero.
  - Last beat with tkeep not of the form 0..01..1.
- Length error: completed length < MIN_PKT_BYTES or > MAX_PKT_BYTES.
- Mismatch error: completed length differs from the captured tuser length.
- Stats update on the cycle after the completing beat.
  - pkt_count += 1, byte_count += length, last_pkt_len and last_src_port load.
  - err_count += 1 (saturating at 16'hFFFF) if any error was seen in that packet.
  - The relevant err_flags bits set and stay set.
- pkt_count and byte_count wrap modulo 2^32 and 2^48.
- clear_stats: clears counters, flags, last_pkt_len and last_src_port. It does not affect the FSM or the LFSR.
- If clear_stats and a stats update land on the same cycle, clear wins and that packet is not counted.
- Reset mid-packet discards the partial packet. Beats arriving after reset start a new packet, so the bench must hold tvalid low across reset.

Optional Feature:
SINK_STALL_CHECK_EN:
- Defined: while tvalid=1 and tready=0, the block registers tdata, tkeep, tuser and tlast.
- Defined: err_flags[3] sets, and the current packet counts as errored, if on the next cycle tvalid drops or any registered field changes before acceptance.
- Not defined: err_flags[3] is tied 0 and no stall registers exist.

Test Plan:
- THROTTLE_PERCENT=0, enable=1, one 64-byte packet in 2 beats of tkeep 32'hFFFFFFFF, tuser[15:0]=64, tuser[23:16]=8'h04 -> pkt_count=1, byte_count=64, last_pkt_len=64, last_src_port=8'h04, err_flags=0.
- 3-beat 70-byte packet, last tkeep 32'h0000003F, tuser length=70, THROTTLE_PERCENT=50 -> accepted with stalls, last_pkt_len=70, no errors, busy low after the completing beat.
- Last beat tkeep 32'h0000F0FF -> err_flags[0]=1, err_count=1. A 40-byte packet -> err_flags[1]=1. tuser length 100 with 96 bytes sent -> err_flags[2]=1.
- clear_stats pulsed on the update cycle of a 64-byte packet -> all stats 0 afterwards.
- Reset asserted after beat 1 of 3, tvalid held low, then a clean 64-byte packet -> pkt_count=1, no errors.
- With SINK_STALL_CHECK_EN defined, change tdata while tready=0 -> err_flags[3]=1. Without the macro, the same stimulus -> err_flags[3]=0.

Source files
------------

// File: rtl/axis_sim_pkt_sink.sv
// AXI4-Stream packet sink and checker: LFSR backpressure, tkeep/length checks, packet statistics.
// Optional macro SINK_STALL_CHECK_EN adds a check that a stalled beat is held stable until accepted.
module axis_sim_pkt_sink #(
   parameter int          C_S_AXIS_DATA_WIDTH  = 256,
   parameter int          C_S_AXIS_TUSER_WIDTH = 128,
   parameter int          THROTTLE_PERCENT     = 50,
   parameter logic [15:0] LFSR_SEED            = 16'hACE1,
   parameter int          MIN_PKT_BYTES        = 60,
   parameter int          MAX_PKT_BYTES        = 1518
) (
   input  logic                               axis_aclk,
   input  logic                               axis_resetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
   input  logic                               s_axis_tvalid,
   output logic                               s_axis_tready,
   input  logic                               s_axis_tlast,
   input  logic                               enable,
   input  logic                               clear_stats,
   output logic [31:0]                        pkt_count,
   output logic [47:0]                        byte_count,
   output logic [15:0]                        err_count,
   output logic [3:0]                         err_flags,
   output logic [15:0]                        last_pkt_len,
   output logic [7:0]                         last_src_port,
   output logic                               busy
);

   localparam int         KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
   localparam int         CNT_W  = $clog2(KEEP_W + 1);
   localparam logic [7:0] THRESH = 8'(THROTTLE_PERCENT * 256 / 100);

   localparam int E_KEEP  = 0;
   localparam int E_LEN   = 1;
   localparam int E_MISM  = 2;
   localparam int E_STALL = 3;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PKT  = 1'b1
   } state_e;

   function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_W-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < KEEP_W; i++) n = n + CNT_W'(v[i]);
      return n;
   endfunction

   state_e      state_q, state_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic        tready_q, tready_d;

   logic [15:0] len_q, len_d;
   logic [15:0] exp_len_q, exp_len_d;
   logic [7:0]  src_q, src_d;
   logic        kerr_q, kerr_d;
   logic        mark_q, mark_d;

   logic        upd_q, upd_d;
   logic [15:0] upd_len_q, upd_len_d;
   logic [7:0]  upd_src_q, upd_src_d;
   logic [3:0]  upd_err_q, upd_err_d;

   logic [31:0] pkt_count_q, pkt_count_d;
   logic [47:0] byte_count_q, byte_count_d;
   logic [15:0] err_count_q, err_count_d;
   logic [3:0]  err_flags_q, err_flags_d;
   logic [15:0] last_len_q, last_len_d;
   logic [7:0]  last_src_q, last_src_d;

   logic              accept;
   logic              stall_viol;
   logic [CNT_W-1:0]  beat_bytes;
   logic [KEEP_W-1:0] keep_inc;
   logic              beat_kerr;
   logic [15:0]       base_len;
   logic              base_kerr;
   logic [15:0]       cur_exp;
   logic [7:0]        cur_src;
   logic [16:0]       len_sum;
   logic [15:0]       new_len;
   logic              new_kerr;
   logic              mark_acc;

   assign accept = s_axis_tvalid & tready_q;

   // Fibonacci LFSR, taps 16,14,13,11; tready is decided one cycle ahead from its low byte.
   assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign tready_d = enable & (lfsr_q[7:0] >= THRESH);

`ifdef SINK_STALL_CHECK_EN
   logic                              stall_q;
   logic [C_S_AXIS_DATA_WIDTH-1:0]    hold_data_q;
   logic [KEEP_W-1:0]                 hold_keep_q;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]   hold_user_q;
   logic                              hold_last_q;

   assign stall_viol = stall_q & (~s_axis_tvalid
                                  | (s_axis_tdata != hold_data_q)
                                  | (s_axis_tkeep != hold_keep_q)
                                  | (s_axis_tuser != hold_user_q)
                                  | (s_axis_tlast != hold_last_q));

   always_ff @(posedge axis_aclk) begin
      if (!axis_resetn) stall_q <= 1'b0;
      else              stall_q <= s_axis_tvalid & ~tready_q;
   end

   // NOTE: the hold registers are plain datapath qualified by stall_q, so they carry no reset.
   always_ff @(posedge axis_aclk) begin
      if (s_axis_tvalid & ~tready_q) begin
         hold_data_q <= s_axis_tdata;
         hold_keep_q <= s_axis_tkeep;
         hold_user_q <= s_axis_tuser;
         hold_last_q <= s_axis_tlast;
      end
   end
`else
   logic unused_stall_inputs;
   assign stall_viol          = 1'b0;
   assign unused_stall_inputs = ^{s_axis_tdata, s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:24]};
`endif

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latches can be inferred.
      state_d   = state_q;
      len_d     = len_q;
      exp_len_d = exp_len_q;
      src_d     = src_q;
      kerr_d    = kerr_q;
      upd_d     = 1'b0;
      upd_len_d = upd_len_q;
      upd_src_d = upd_src_q;
      upd_err_d = upd_err_q;

      beat_bytes = popcount(s_axis_tkeep);
      keep_inc   = s_axis_tkeep + KEEP_W'(1);
      // A last beat must be a nonzero run of ones from bit 0; earlier beats must be full.
      beat_kerr  = s_axis_tlast ? ((s_axis_tkeep == '0) | ((s_axis_tkeep & keep_inc) != '0))
                                : ~(&s_axis_tkeep);

      base_len  = (state_q == S_PKT) ? len_q : 16'd0;
      base_kerr = (state_q == S_PKT) & kerr_q;
      cur_exp   = (state_q == S_PKT) ? exp_len_q : s_axis_tuser[15:0];
      cur_src   = (state_q == S_PKT) ? src_q : s_axis_tuser[23:16];
      len_sum   = {1'b0, base_len} + 17'(beat_bytes);
      new_len   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
      new_kerr  = base_kerr | beat_kerr;
      mark_acc  = mark_q | stall_viol;
      mark_d    = mark_acc;

      if (accept) begin
         len_d     = new_len;
         kerr_d    = new_kerr;
         exp_len_d = cur_exp;
         src_d     = cur_src;
         if (s_axis_tlast) begin
            state_d   = S_IDLE;
            upd_d     = 1'b1;
            upd_len_d = new_len;
            upd_src_d = cur_src;
            upd_err_d = {mark_acc,
                         new_len != cur_exp,
                         (new_len < 16'(MIN_PKT_BYTES)) | (new_len > 16'(MAX_PKT_BYTES)),
                         new_kerr};
            mark_d    = 1'b0;
         end else begin
            state_d = S_PKT;
         end
      end
   end

   // Statistics trail the completing beat by one cycle; a coincident clear drops that packet.
   always_comb begin
      pkt_count_d  = pkt_count_q;
      byte_count_d = byte_count_q;
      err_count_d  = err_count_q;
      err_flags_d  = err_flags_q;
      last_len_d   = last_len_q;
      last_src_d   = last_src_q;

      if (clear_stats) begin
         pkt_count_d  = '0;
         byte_count_d = '0;
         err_count_d  = '0;
         err_flags_d  = '0;
         last_len_d   = '0;
         last_src_d   = '0;
      end else begin
         if (upd_q) begin
            pkt_count_d  = pkt_count_q + 32'd1;
            byte_count_d = byte_count_q + 48'(upd_len_q);
            last_len_d   = upd_len_q;
            last_src_d   = upd_src_q;
            err_flags_d  = err_flags_q | upd_err_q;
            if ((upd_err_q != 4'd0) && (err_count_q != 16'hFFFF))
               err_count_d = err_count_q + 16'd1;
         end
         if (stall_viol) err_flags_d[E_STALL] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register updates together.
   always_ff @(posedge axis_aclk) begin
      if (!axis_resetn) begin
         state_q      <= S_IDLE;
         lfsr_q       <= LFSR_SEED;
         tready_q     <= 1'b0;
         len_q        <= '0;
         exp_len_q    <= '0;
         src_q        <= '0;
         kerr_q       <= 1'b0;
         mark_q       <= 1'b0;
         upd_q        <= 1'b0;
         upd_len_q    <= '0;
         upd_src_q    <= '0;
         upd_err_q    <= '0;
         pkt_count_q  <= '0;
         byte_count_q <= '0;
         err_count_q  <= '0;
         err_flags_q  <= '0;
         last_len_q   <= '0;
         last_src_q   <= '0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         tready_q     <= tready_d;
         len_q        <= len_d;
         exp_len_q    <= exp_len_d;
         src_q        <= src_d;
         kerr_q       <= kerr_d;
         mark_q       <= mark_d;
         upd_q        <= upd_d;
         upd_len_q    <= upd_len_d;
         upd_src_q    <= upd_src_d;
         upd_err_q    <= upd_err_d;
         pkt_count_q  <= pkt_count_d;
         byte_count_q <= byte_count_d;
         err_count_q  <= err_count_d;
         err_flags_q  <= err_flags_d;
         last_len_q   <= last_len_d;
         last_src_q   <= last_src_d;
      end
   end

   assign s_axis_tready = tready_q;
   assign pkt_count     = pkt_count_q;
   assign byte_count    = byte_count_q;
   assign err_count     = err_count_q;
   assign err_flags     = err_flags_q;
   assign last_pkt_len  = last_len_q;
   assign last_src_port = last_src_q;
   assign busy          = (state_q == S_PKT);

endmodule
